// File: rtl/biriscv_mcycle_sched_pkg.sv
// Shared types for the multi-cycle scheduler: FSM states and the one-hot
// op-type encoding used on the backend command interface.
package biriscv_mcycle_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // Bit 0 drives unit_div_o, bit 1 drives unit_mule_o.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_DIV  = 2'b01,
    OP_MULE = 2'b10
  } op_t;

  // A request with both type bits set is a divide.
  function automatic op_t decode_op(input logic is_div, input logic is_mule);
    if (is_div)
      return OP_DIV;
    else if (is_mule)
      return OP_MULE;
    else
      return OP_NONE;
  endfunction

  function automatic logic op_supported(input op_t op, input logic div_ok,
                                        input logic mule_ok);
    return ((op == OP_DIV) && div_ok) || ((op == OP_MULE) && mule_ok);
  endfunction

endpackage

// File: rtl/biriscv_mcycle_sched.sv
// Arbitrates the two issue slots onto the shared divider/mule backend, tracks
// the in-flight destination register and returns tagged results.
module biriscv_mcycle_sched
  import biriscv_mcycle_sched_pkg::*;
#(
  parameter int SUPPORT_DIV  = 1,
  parameter int SUPPORT_MULE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  input  logic        req0_div_i,
  input  logic        req0_mule_i,
  input  logic [31:0] req0_opcode_i,
  input  logic [31:0] req0_ra_i,
  input  logic [31:0] req0_rb_i,
  input  logic [4:0]  req0_rd_i,
  output logic        req0_accept_o,
  input  logic        req1_valid_i,
  input  logic        req1_div_i,
  input  logic        req1_mule_i,
  input  logic [31:0] req1_opcode_i,
  input  logic [31:0] req1_ra_i,
  input  logic [31:0] req1_rb_i,
  input  logic [4:0]  req1_rd_i,
  output logic        req1_accept_o,
  input  logic        squash_i,
  output logic        unit_valid_o,
  output logic        unit_div_o,
  output logic        unit_mule_o,
  output logic [31:0] unit_opcode_o,
  output logic [31:0] unit_ra_o,
  output logic [31:0] unit_rb_o,
  input  logic        unit_accept_i,
  input  logic        div_complete_i,
  input  logic        mule_complete_i,
  input  logic [31:0] div_result_i,
  input  logic [31:0] mule_result_i,
  output logic        busy_o,
  output logic [4:0]  busy_rd_o,
  output logic        complete_o,
  output logic        complete_slot_o,
  output logic [4:0]  complete_rd_o,
  output logic [31:0] complete_result_o,
  output logic [31:0] busy_cycles_o
);

  localparam logic DIV_OK  = (SUPPORT_DIV != 0);
  localparam logic MULE_OK = (SUPPORT_MULE != 0);

  state_t      state_q, state_d;
  op_t         op_q, op_d;
  logic [31:0] opcode_q, opcode_d;
  logic [31:0] ra_q, ra_d;
  logic [31:0] rb_q, rb_d;
  logic [4:0]  rd_q, rd_d;
  logic        slot_q, slot_d;
  logic [31:0] result_q, result_d;
  logic [31:0] busy_cycles_q, busy_cycles_d;

  op_t  op0, op1;
  logic qual0, qual1;
  logic match_complete;

  always_comb begin
    op0   = decode_op(req0_div_i, req0_mule_i);
    op1   = decode_op(req1_div_i, req1_mule_i);
    qual0 = req0_valid_i && op_supported(op0, DIV_OK, MULE_OK) && !squash_i;
    qual1 = req1_valid_i && op_supported(op1, DIV_OK, MULE_OK) && !squash_i;

    req0_accept_o = (state_q == ST_IDLE) && qual0;
    req1_accept_o = (state_q == ST_IDLE) && qual1 && !qual0;

    match_complete = ((op_q == OP_DIV) && div_complete_i) ||
                     ((op_q == OP_MULE) && mule_complete_i);
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    opcode_d      = opcode_q;
    ra_d          = ra_q;
    rb_d          = rb_q;
    rd_d          = rd_q;
    slot_d        = slot_q;
    result_d      = result_q;
    busy_cycles_d = (state_q != ST_IDLE) ? busy_cycles_q + 32'd1 : busy_cycles_q;

    case (state_q)
      ST_IDLE: begin
        if (req0_accept_o) begin
          op_d     = op0;
          opcode_d = req0_opcode_i;
          ra_d     = req0_ra_i;
          rb_d     = req0_rb_i;
          rd_d     = req0_rd_i;
          slot_d   = 1'b0;
          state_d  = ST_REQ;
        end else if (req1_accept_o) begin
          op_d     = op1;
          opcode_d = req1_opcode_i;
          ra_d     = req1_ra_i;
          rb_d     = req1_rb_i;
          rd_d     = req1_rd_i;
          slot_d   = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (squash_i)
          state_d = ST_IDLE;
        else if (unit_accept_i)
          state_d = ST_WAIT;
      end
      // Squash beats a same-cycle completion; DRAIN then waits for a fresh one.
      ST_WAIT: begin
        if (squash_i)
          state_d = ST_DRAIN;
        else if (match_complete) begin
          result_d = (op_q == OP_DIV) ? div_result_i : mule_result_i;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_DRAIN: begin
        if (match_complete)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_NONE;
      opcode_q      <= 32'd0;
      ra_q          <= 32'd0;
      rb_q          <= 32'd0;
      rd_q          <= 5'd0;
      slot_q        <= 1'b0;
      result_q      <= 32'd0;
      busy_cycles_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      opcode_q      <= opcode_d;
      ra_q          <= ra_d;
      rb_q          <= rb_d;
      rd_q          <= rd_d;
      slot_q        <= slot_d;
      result_q      <= result_d;
      busy_cycles_q <= busy_cycles_d;
    end
  end

  assign unit_valid_o      = (state_q == ST_REQ);
  assign unit_div_o        = (op_q == OP_DIV);
  assign unit_mule_o       = (op_q == OP_MULE);
  assign unit_opcode_o     = opcode_q;
  assign unit_ra_o         = ra_q;
  assign unit_rb_o         = rb_q;
  assign busy_o            = (state_q != ST_IDLE);
  assign busy_rd_o         = ((state_q == ST_REQ) || (state_q == ST_WAIT) ||
                              (state_q == ST_RESP)) ? rd_q : 5'd0;
  assign complete_o        = (state_q == ST_RESP) && !squash_i;
  assign complete_slot_o   = slot_q;
  assign complete_rd_o     = rd_q;
  assign complete_result_o = result_q;
  assign busy_cycles_o     = busy_cycles_q;

endmodule

// File: tb/tb_biriscv_mcycle_sched.sv
// Directed table-driven bench for biriscv_mcycle_sched plus hand sequences for
// reset mid-operation and the mule-disabled configuration.
module tb_biriscv_mcycle_sched;

  localparam int OPN = 0;
  localparam int OPD = 1;
  localparam int OPM = 2;
  localparam int NUM_VECS = 38;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic        req0_valid, req0_div, req0_mule, req1_valid, req1_div, req1_mule;
  logic [31:0] req0_opcode, req0_ra, req0_rb, req1_opcode, req1_ra, req1_rb;
  logic [4:0]  req0_rd, req1_rd;
  logic        squash, unit_accept, div_complete, mule_complete;
  logic [31:0] div_result, mule_result;

  logic        acc0, acc1, unit_valid, unit_div, unit_mule;
  logic [31:0] unit_opcode, unit_ra, unit_rb;
  logic        busy, complete, complete_slot;
  logic [4:0]  busy_rd, complete_rd;
  logic [31:0] complete_result, busy_cycles;

  logic        nm_req0_valid, nm_req0_div, nm_req0_mule, nm_squash;
  logic        nm_acc0, nm_acc1, nm_unit_valid, nm_unit_div, nm_unit_mule;
  logic [31:0] nm_unit_opcode, nm_unit_ra, nm_unit_rb;
  logic        nm_busy, nm_complete, nm_complete_slot;
  logic [4:0]  nm_busy_rd, nm_complete_rd;
  logic [31:0] nm_complete_result, nm_busy_cycles;

  biriscv_mcycle_sched #(.SUPPORT_DIV(1), .SUPPORT_MULE(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid), .req0_div_i(req0_div), .req0_mule_i(req0_mule),
    .req0_opcode_i(req0_opcode), .req0_ra_i(req0_ra), .req0_rb_i(req0_rb),
    .req0_rd_i(req0_rd), .req0_accept_o(acc0),
    .req1_valid_i(req1_valid), .req1_div_i(req1_div), .req1_mule_i(req1_mule),
    .req1_opcode_i(req1_opcode), .req1_ra_i(req1_ra), .req1_rb_i(req1_rb),
    .req1_rd_i(req1_rd), .req1_accept_o(acc1),
    .squash_i(squash),
    .unit_valid_o(unit_valid), .unit_div_o(unit_div), .unit_mule_o(unit_mule),
    .unit_opcode_o(unit_opcode), .unit_ra_o(unit_ra), .unit_rb_o(unit_rb),
    .unit_accept_i(unit_accept),
    .div_complete_i(div_complete), .mule_complete_i(mule_complete),
    .div_result_i(div_result), .mule_result_i(mule_result),
    .busy_o(busy), .busy_rd_o(busy_rd),
    .complete_o(complete), .complete_slot_o(complete_slot),
    .complete_rd_o(complete_rd), .complete_result_o(complete_result),
    .busy_cycles_o(busy_cycles)
  );

  biriscv_mcycle_sched #(.SUPPORT_DIV(1), .SUPPORT_MULE(0)) dut_nomule (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(nm_req0_valid), .req0_div_i(nm_req0_div), .req0_mule_i(nm_req0_mule),
    .req0_opcode_i(32'h0000_0001), .req0_ra_i(32'd11), .req0_rb_i(32'd2),
    .req0_rd_i(5'd3), .req0_accept_o(nm_acc0),
    .req1_valid_i(1'b0), .req1_div_i(1'b0), .req1_mule_i(1'b0),
    .req1_opcode_i(32'd0), .req1_ra_i(32'd0), .req1_rb_i(32'd0),
    .req1_rd_i(5'd0), .req1_accept_o(nm_acc1),
    .squash_i(nm_squash),
    .unit_valid_o(nm_unit_valid), .unit_div_o(nm_unit_div), .unit_mule_o(nm_unit_mule),
    .unit_opcode_o(nm_unit_opcode), .unit_ra_o(nm_unit_ra), .unit_rb_o(nm_unit_rb),
    .unit_accept_i(1'b0),
    .div_complete_i(1'b0), .mule_complete_i(1'b0),
    .div_result_i(32'd0), .mule_result_i(32'd0),
    .busy_o(nm_busy), .busy_rd_o(nm_busy_rd),
    .complete_o(nm_complete), .complete_slot_o(nm_complete_slot),
    .complete_rd_o(nm_complete_rd), .complete_result_o(nm_complete_result),
    .busy_cycles_o(nm_busy_cycles)
  );

  // One row per clock: inputs for that cycle and the outputs expected in it.
  typedef struct {
    int          r0op, r1op, sq, ua, dc, mc;
    logic [31:0] res;
    int          acc0, acc1, uv, uop;
    logic [31:0] ra;
    int          busy, brd, cmp, cslot, crd;
    logic [31:0] cres, cnt;
  } vec_t;

  vec_t vecs [NUM_VECS];
  int   passed = 0;
  int   total  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic applyStimulus(input vec_t v);
    req0_valid    = (v.r0op != OPN);
    req0_div      = (v.r0op == OPD);
    req0_mule     = (v.r0op == OPM);
    req1_valid    = (v.r1op != OPN);
    req1_div      = (v.r1op == OPD);
    req1_mule     = (v.r1op == OPM);
    squash        = (v.sq != 0);
    unit_accept   = (v.ua != 0);
    div_complete  = (v.dc != 0);
    mule_complete = (v.mc != 0);
    div_result    = v.res;
    mule_result   = v.res;
  endtask

  task automatic checkRow(input int i, input vec_t v);
    checkOutput($sformatf("row%0d acc0", i), {31'd0, acc0}, v.acc0);
    checkOutput($sformatf("row%0d acc1", i), {31'd0, acc1}, v.acc1);
    checkOutput($sformatf("row%0d unit_valid", i), {31'd0, unit_valid}, v.uv);
    if (v.uv != 0) begin
      checkOutput($sformatf("row%0d unit_op", i), {30'd0, unit_mule, unit_div}, v.uop);
      checkOutput($sformatf("row%0d unit_ra", i), unit_ra, v.ra);
    end
    checkOutput($sformatf("row%0d busy", i), {31'd0, busy}, v.busy);
    checkOutput($sformatf("row%0d busy_rd", i), {27'd0, busy_rd}, v.brd);
    checkOutput($sformatf("row%0d complete", i), {31'd0, complete}, v.cmp);
    if (v.cmp != 0) begin
      checkOutput($sformatf("row%0d complete_slot", i), {31'd0, complete_slot}, v.cslot);
      checkOutput($sformatf("row%0d complete_rd", i), {27'd0, complete_rd}, v.crd);
      checkOutput($sformatf("row%0d complete_result", i), complete_result, v.cres);
    end
    checkOutput($sformatf("row%0d busy_cycles", i), busy_cycles, v.cnt);
  endtask

  initial begin
    // r0op r1op sq ua dc mc res | acc0 acc1 uv uop ra | busy brd cmp cslot crd cres | cnt
    vecs[0]  = '{OPD,OPN,0,0,0,0,32'd0,  1,0,0,OPN,32'd0,   0,0,0,0,0,32'd0, 32'd0};
    vecs[1]  = '{OPN,OPN,0,0,0,0,32'd0,  0,0,1,OPD,32'd100, 1,5,0,0,0,32'd0, 32'd0};
    vecs[2]  = '{OPN,OPN,0,0,0,0,32'd0,  0,0,1,OPD,32'd100, 1,5,0,0,0,32'd0, 32'd1};
    vecs[3]  = '{OPN,OPN,0,1,0,0,32'd0,  0,0,1,OPD,32'd100, 1,5,0,0,0,32'd0, 32'd2};
    vecs[4]  = '{OPN,OPN,0,0,0,0,32'd0,  0,0,0,OPN,32'd0,   1,5,0,0,0,32'd0, 32'd3};
    vecs[5]  = '{OPN,OPN,0,0,0,0,32'd0,  0,0,0,OPN,32'd0,   1,5,0,0,0,32'd0, 32'd4};
    vecs[6]  = '{OPN,OPN,0,0,0,0,32'd0,  0,0,0,OPN,32'd0,   1,5,0,0,0,32'd0, 32'd5};
    vecs[7]  = '{OPN,OPN,0,0,0,0,32'd0,  0,0,0,OPN,32'd0,   1,5,0,0,0,32'd0, 32'd6};
    vecs[8]  = '{OPN,OPN,0,0,1,0,32'd14, 0,0,0,OPN,32'd0,   1,5,0,0,0,32'd0, 32'd7};
    vecs[9]  = '{OPN,OPN,0,0,0,0,32'd0,  0,0,0,OPN,32'd0,   1,5,1,0,5,32'd14, 32'd8};
    vecs[10] = '{OPM,OPD,0,0,0,0,32'd0,  1,0,0,OPN,32'd0,   0,0,0,0,0,32'd0, 32'd9};
    vecs[11] = '{OPN,OPD,0,1,0,0,32'd0,  0,0,1,OPM,32'd100, 1,5,0,0,0,32'd0, 32'd9};
    vecs[12] = '{OPN,OPD,0,0,1,0,32'd0,  0,0,0,OPN,32'd0,   1,5,0,0,0,32'd0, 32'd10};
    vecs[13] = '{OPN,OPD,0,0,0,1,32'hDEADBEEF, 0,0,0,OPN,32'd0, 1,5,0,0,0,32'd0, 32'd11};
    vecs[14] = '{OPN,OPD,0,0,0,0,32'd0,  0,0,0,OPN,32'd0,   1,5,1,0,5,32'hDEADBEEF, 32'd12};
    vecs[15] = '{OPN,OPD,0,0,0,0,32'd0,  0,1,0,OPN,32'd0,   0,0,0,0,0,32'd0, 32'd13};
    vecs[16] = '{OPN,OPN,0,1,0,0,32'd0,  0,0,1,OPD,32'd200, 1,9,0,0,0,32'd0, 32'd13};
    vecs[17] = '{OPN,OPN,0,0,1,0,32'd21, 0,0,0,OPN,32'd0,   1,9,0,0,0,32'd0, 32'd14};
    vecs[18] = '{OPN,OPN,0,0,0,0,32'd0,  0,0,0,OPN,32'd0,   1,9,1,1,9,32'd21, 32'd15};
    vecs[19] = '{OPD,OPN,0,0,0,0,32'd0,  1,0,0,OPN,32'd0,   0,0,0,0,0,32'd0, 32'd16};
    vecs[20] = '{OPN,OPN,0,1,0,0,32'd0,  0,0,1,OPD,32'd100, 1,5,0,0,0,32'd0, 32'd16};
    vecs[21] = '{OPN,OPN,1,0,0,0,32'd0,  0,0,0,OPN,32'd0,   1,5,0,0,0,32'd0, 32'd17};
    vecs[22] = '{OPN,OPN,0,0,0,0,32'd0,  0,0,0,OPN,32'd0,   1,0,0,0,0,32'd0, 32'd18};
    vecs[23] = '{OPN,OPN,0,0,1,0,32'd77, 0,0,0,OPN,32'd0,   1,0,0,0,0,32'd0, 32'd19};
    vecs[24] = '{OPD,OPN,1,0,0,0,32'd0,  0,0,0,OPN,32'd0,   0,0,0,0,0,32'd0, 32'd20};
    vecs[25] = '{OPM,OPN,0,0,0,0,32'd0,  1,0,0,OPN,32'd0,   0,0,0,0,0,32'd0, 32'd20};
    vecs[26] = '{OPN,OPN,1,0,0,0,32'd0,  0,0,1,OPM,32'd100, 1,5,0,0,0,32'd0, 32'd20};
    vecs[27] = '{OPN,OPN,0,0,0,1,32'd99, 0,0,0,OPN,32'd0,   0,0,0,0,0,32'd0, 32'd21};
    vecs[28] = '{OPN,OPD,0,0,0,0,32'd0,  0,1,0,OPN,32'd0,   0,0,0,0,0,32'd0, 32'd21};
    vecs[29] = '{OPN,OPN,0,1,0,0,32'd0,  0,0,1,OPD,32'd200, 1,9,0,0,0,32'd0, 32'd21};
    vecs[30] = '{OPN,OPN,1,0,1,0,32'd33, 0,0,0,OPN,32'd0,   1,9,0,0,0,32'd0, 32'd22};
    vecs[31] = '{OPN,OPN,0,0,0,0,32'd0,  0,0,0,OPN,32'd0,   1,0,0,0,0,32'd0, 32'd23};
    vecs[32] = '{OPN,OPN,0,0,1,0,32'd44, 0,0,0,OPN,32'd0,   1,0,0,0,0,32'd0, 32'd24};
    vecs[33] = '{OPD,OPN,0,0,0,0,32'd0,  1,0,0,OPN,32'd0,   0,0,0,0,0,32'd0, 32'd25};
    vecs[34] = '{OPN,OPN,0,1,0,0,32'd0,  0,0,1,OPD,32'd100, 1,5,0,0,0,32'd0, 32'd25};
    vecs[35] = '{OPN,OPN,0,0,1,0,32'd55, 0,0,0,OPN,32'd0,   1,5,0,0,0,32'd0, 32'd26};
    vecs[36] = '{OPN,OPN,1,0,0,0,32'd0,  0,0,0,OPN,32'd0,   1,5,0,0,0,32'd0, 32'd27};
    vecs[37] = '{OPN,OPN,0,0,0,0,32'd0,  0,0,0,OPN,32'd0,   0,0,0,0,0,32'd0, 32'd28};

    rst_i = 1'b1;
    req0_opcode = 32'h0200_4033; req0_ra = 32'd100; req0_rb = 32'd7; req0_rd = 5'd5;
    req1_opcode = 32'h0200_5033; req1_ra = 32'd200; req1_rb = 32'd3; req1_rd = 5'd9;
    applyStimulus(vecs[37]);
    nm_req0_valid = 1'b0; nm_req0_div = 1'b0; nm_req0_mule = 1'b0; nm_squash = 1'b0;

    #12;
    checkOutput("reset unit_valid", {31'd0, unit_valid}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset busy_rd", {27'd0, busy_rd}, 32'd0);
    checkOutput("reset complete", {31'd0, complete}, 32'd0);
    checkOutput("reset unit_ra", unit_ra, 32'd0);
    checkOutput("reset complete_result", complete_result, 32'd0);
    checkOutput("reset busy_cycles", busy_cycles, 32'd0);
    #10 rst_i = 1'b0;

    for (int i = 0; i < NUM_VECS; i++) begin
      @(posedge clk_i);
      #2 applyStimulus(vecs[i]);
      #2 checkRow(i, vecs[i]);
    end

    // Reset asserted while waiting on the backend; a late completion is ignored.
    @(posedge clk_i); #2 applyStimulus(vecs[19]);
    @(posedge clk_i); #2 applyStimulus(vecs[20]);
    @(posedge clk_i); #2 applyStimulus(vecs[37]);
    #1 checkOutput("midop pre-reset busy", {31'd0, busy}, 32'd1);
    rst_i = 1'b1;
    #1;
    checkOutput("midop reset busy", {31'd0, busy}, 32'd0);
    checkOutput("midop reset busy_rd", {27'd0, busy_rd}, 32'd0);
    checkOutput("midop reset busy_cycles", busy_cycles, 32'd0);
    @(posedge clk_i); #2 rst_i = 1'b0; div_complete = 1'b1; div_result = 32'd123;
    @(posedge clk_i); #2 div_complete = 1'b0;
    #1;
    checkOutput("post-reset complete", {31'd0, complete}, 32'd0);
    checkOutput("post-reset busy", {31'd0, busy}, 32'd0);
    checkOutput("post-reset busy_cycles", busy_cycles, 32'd0);

    // Mule requests never accepted when the mule is compiled out.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i); #2 nm_req0_valid = 1'b1; nm_req0_mule = 1'b1; nm_req0_div = 1'b0;
      #2;
      checkOutput($sformatf("nomule acc0 c%0d", c), {31'd0, nm_acc0}, 32'd0);
      checkOutput($sformatf("nomule busy c%0d", c), {31'd0, nm_busy}, 32'd0);
    end
    @(posedge clk_i); #2 nm_req0_div = 1'b1;
    #2 checkOutput("nomule both-bits acc0", {31'd0, nm_acc0}, 32'd1);
    @(posedge clk_i); #2 nm_req0_valid = 1'b0; nm_req0_div = 1'b0; nm_req0_mule = 1'b0;
    nm_squash = 1'b1;
    #2;
    checkOutput("nomule unit_valid", {31'd0, nm_unit_valid}, 32'd1);
    checkOutput("nomule unit_op", {30'd0, nm_unit_mule, nm_unit_div}, 32'd1);
    checkOutput("nomule busy_rd", {27'd0, nm_busy_rd}, 32'd3);
    @(posedge clk_i); #2 nm_squash = 1'b0;
    #2;
    checkOutput("nomule squash unit_valid", {31'd0, nm_unit_valid}, 32'd0);
    checkOutput("nomule squash busy", {31'd0, nm_busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/biriscv_mcycle_sched.md
# biriscv_mcycle_sched

Scheduler that shares one out-of-pipe multi-cycle execution backend (iterative divider plus extended multiplier "mule") between the two issue slots of the dual-issue core. It accepts one request at a time with fixed priority: slot 0 is older and wins over slot 1. It holds the request until the backend accepts it, then waits for the matching completion and returns the result with its rd and slot tag. It also tracks the busy destination register for the hazard scoreboard and handles pipeline squash mid-operation.

## Interface
- SUPPORT_DIV, 1, when 0 div requests are never accepted (req accept forced low for div)
- SUPPORT_MULE, 1, when 0 mule requests are never accepted
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- reqN_valid_i  in  1  request from slot N (N=0,1)
- reqN_div_i / reqN_mule_i  in  1  op type; both set → div; neither set → not a request
- reqN_opcode_i, reqN_ra_i, reqN_rb_i  in  32 each  instruction and operands
- reqN_rd_i  in  5  destination register
- reqN_accept_o  out  1  combinational; request captured this cycle
- squash_i  in  1  pipeline flush; abort or discard the current op
- unit_valid_o  out  1  command to backend
- unit_div_o, unit_mule_o  out  1 each  one-hot op select
- unit_opcode_o, unit_ra_o, unit_rb_o  out  32 each  captured command
- unit_accept_i  in  1  backend accepted command
- div_complete_i, mule_complete_i  in  1 each  backend done pulses
- div_result_i, mule_result_i  in  32 each  backend results
- busy_o  out  1  state ≠ IDLE
- busy_rd_o  out  5  rd of the live op; 0 when IDLE or DRAIN
- complete_o  out  1  result valid, single cycle
- complete_slot_o  out  1  originating slot
- complete_rd_o  out  5  destination register
- complete_result_o  out  32  result
- busy_cycles_o  out  32  performance counter

## Operation
- FSM states: IDLE, REQ, WAIT, RESP, DRAIN.
- IDLE: a qualified request (valid, op type supported, squash_i low) is accepted. Slot 0 takes priority. Only one accept can be high per cycle. The accepted op, operands, rd and slot are captured. Next state is REQ.
- REQ: unit_valid_o=1. Command fields are held stable until unit_accept_i. On accept, next state is WAIT. If squash_i is high, go to IDLE and drop unit_valid_o; this is the only legal withdrawal of a command.
- WAIT: on the completion signal matching the captured op type, the result is registered and next state is RESP. A completion of the non-matching type is ignored. If squash_i is high, go to DRAIN.
- RESP: complete_o = ~squash_i. Next state is IDLE. No accept is made in RESP.
- DRAIN: wait for the matching completion, discard the result, then go to IDLE. complete_o stays 0.
- busy_cycles_o increments every cycle state ≠ IDLE and wraps modulo 2^32.
- Squash in the same cycle as a completion in WAIT: DRAIN takes priority and the result is discarded. DRAIN then waits for a new completion.

## Timing
- Reset values: state=IDLE, all outputs 0, busy_cycles_o=0, captured registers 0.
- Accept at cycle N → unit_valid_o high at N+1.
- unit_accept_i at N+1 → WAIT at N+2.
- Completion at cycle M in WAIT → complete_o at M+1 → IDLE at M+2. The earliest next accept is at M+2.
- Minimum request-to-complete time is 4 cycles, with a backend that accepts immediately and completes on the first WAIT cycle.
- busy_rd_o is valid from N+1 through RESP inclusive.
- Reset asserted mid-operation returns the block to IDLE immediately. Any later backend completion is ignored.

## Structure
- FSM state encoding and the op-type encoding (DIV, MULE) go in biriscv_defs.v as shared defines, next to the existing exception and PCINFO constants.
- No sub-module. Priority select, FSM and counter are inline; expected size is about 200 lines.

## Test plan
- req0 div valid, ra=100, rb=7; backend accepts after 2 cycles and completes 5 cycles later with div_result_i=14 → complete_o pulse, slot=0, rd=req0_rd_i, result=14, busy_cycles_o=9.
- req0 and req1 both valid in the same cycle → req0_accept_o=1, req1_accept_o=0. req1 is accepted at the first IDLE after complete_o, and its complete_slot_o=1.
- mule op in WAIT receives div_complete_i=1 → ignored, stays in WAIT. A later mule_complete_i with result 0xDEADBEEF → complete_result_o=0xDEADBEEF.
- squash_i in WAIT → busy_rd_o=0 next cycle. The later completion produces no complete_o, and the FSM returns to IDLE.
- squash_i in REQ before unit_accept_i → unit_valid_o=0 next cycle and no completion is expected. A request whose valid coincides with squash_i in IDLE gets accept=0.
- SUPPORT_MULE=0 with req0 mule valid → req0_accept_o stays 0 and busy_o stays 0.
